// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Owns the single register-file write port. The in-order pipeline
//   writeback (WB) has priority. Long-latency (LL) results wait in a small
//   FIFO. A starvation counter forces the FIFO head through after
//   STARVE_LIMIT consecutive losses. A WB write kills queued LL results for
//   the same register, because the WB value is younger.
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   WbValid/WbReg/WbData         pipeline writeback request
//   WbStall                      registered; pipeline holds WB while high
//   LlValid/LlReg/LlData/LlReady long-latency handshake into the FIFO
//   RegWriteEn/Reg2Write/Data2Write  registered register-file write port
//   PendingMask                  one bit per register targeted by a live FIFO entry
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int ZERO_REG     = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WbValid,
    input  logic [4:0]  WbReg,
    input  logic [63:0] WbData,
    output logic        WbStall,
    input  logic        LlValid,
    input  logic [4:0]  LlReg,
    input  logic [63:0] LlData,
    output logic        LlReady,
    output logic        RegWriteEn,
    output logic [4:0]  Reg2Write,
    output logic [63:0] Data2Write,
    output logic [31:0] PendingMask
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wb_stall_q, wb_stall_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
    logic [4:0]        ent_reg_q  [DEPTH];
    logic [4:0]        ent_reg_d  [DEPTH];
    logic [63:0]       ent_data_q [DEPTH];
    logic [63:0]       ent_data_d [DEPTH];
    logic              reg_write_en_q, reg_write_en_d;
    logic [4:0]        reg2write_q, reg2write_d;
    logic [63:0]       data2write_q, data2write_d;

    logic          full, empty, head_valid, head_valid_d;
    logic          wb_req, push, pop, pop_write, pop_invalid;
    logic [AW-1:0] rd_idx, wr_idx;

    // FIFO bookkeeping, kill and pop/push decisions
    always_comb begin
        rd_idx      = rd_ptr_q[AW-1:0];
        wr_idx      = wr_ptr_q[AW-1:0];
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        head_valid  = !empty && ent_vld_q[rd_idx];
        // WB is ignored entirely during the forced-drain cycle
        wb_req      = WbValid && !wb_stall_q && (WbReg != 5'(ZERO_REG));
        push        = LlValid && !full && (LlReg != 5'(ZERO_REG));
        // Killed heads leave without using the port, in any state
        pop_invalid = !empty && !ent_vld_q[rd_idx];
        pop_write   = head_valid && ((state_q == FORCE) || (state_q == PEND && !wb_req));
        pop         = pop_invalid || pop_write;

        ent_vld_d  = ent_vld_q;
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        for (int i = 0; i < DEPTH; i++)
            if (wb_req && ent_reg_q[i] == WbReg) ent_vld_d[i] = 1'b0;
        if (pop) ent_vld_d[rd_idx] = 1'b0;
        if (push) begin
            // A same-cycle WB to the same register is younger, so the push lands dead
            ent_vld_d[wr_idx]  = !(wb_req && LlReg == WbReg);
            ent_reg_d[wr_idx]  = LlReg;
            ent_data_d[wr_idx] = LlData;
        end
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        head_valid_d = (wr_ptr_d != rd_ptr_d) && ent_vld_d[rd_ptr_d[AW-1:0]];
    end

    // Next state, starvation counter and write-port selection
    always_comb begin
        state_d        = IDLE;
        cnt_d          = cnt_q;
        reg_write_en_d = 1'b0;
        reg2write_d    = reg2write_q;
        data2write_d   = data2write_q;

        if (state_q == PEND && wb_req) cnt_d = cnt_q + CW'(1);
        if (pop_write)                 cnt_d = '0;

        if (pop_write) begin
            reg_write_en_d = 1'b1;
            reg2write_d    = ent_reg_q[rd_idx];
            data2write_d   = ent_data_q[rd_idx];
        end else if (wb_req) begin
            reg_write_en_d = 1'b1;
            reg2write_d    = WbReg;
            data2write_d   = WbData;
        end

        if (head_valid_d) begin
            if (state_q == PEND && wb_req && cnt_d == CW'(STARVE_LIMIT)) state_d = FORCE;
            else                                                         state_d = PEND;
        end else begin
            cnt_d = '0;
        end
        wb_stall_d = (state_d == FORCE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            wb_stall_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ent_vld_q      <= '0;
            reg_write_en_q <= 1'b0;
            reg2write_q    <= '0;
            data2write_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_stall_q     <= wb_stall_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ent_vld_q      <= ent_vld_d;
            reg_write_en_q <= reg_write_en_d;
            reg2write_q    <= reg2write_d;
            data2write_q   <= data2write_d;
            ent_reg_q      <= ent_reg_d;
            ent_data_q     <= ent_data_d;
        end
    end

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld_q[i]) PendingMask[ent_reg_q[i]] = 1'b1;
    end

    assign LlReady    = !full;
    assign WbStall    = wb_stall_q;
    assign RegWriteEn = reg_write_en_q;
    assign Reg2Write  = reg2write_q;
    assign Data2Write = data2write_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (DEPTH=2, STARVE_LIMIT=4, ZERO_REG=31).
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        WbValid, LlValid;
    logic [4:0]  WbReg, LlReg;
    logic [63:0] WbData, LlData;
    logic        WbStall, LlReady, RegWriteEn;
    logic [4:0]  Reg2Write;
    logic [63:0] Data2Write;
    logic [31:0] PendingMask;
    int          n_cmp = 0;
    int          n_bad = 0;

    writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .ZERO_REG(31)) dut (
        .clk(clk), .rst(rst),
        .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData), .WbStall(WbStall),
        .LlValid(LlValid), .LlReg(LlReg), .LlData(LlData), .LlReady(LlReady),
        .RegWriteEn(RegWriteEn), .Reg2Write(Reg2Write), .Data2Write(Data2Write),
        .PendingMask(PendingMask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        WbValid = 0; WbReg = 0; WbData = 0;
        LlValid = 0; LlReg = 0; LlData = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        #2;
        n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", RegWriteEn); end
        n_cmp++; if (Reg2Write !== 5'd0) begin n_bad++; $display("FAIL reset_reg: got %0d want 0", Reg2Write); end
        n_cmp++; if (Data2Write !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", Data2Write); end
        n_cmp++; if (WbStall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", WbStall); end
        n_cmp++; if (LlReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", LlReady); end
        n_cmp++; if (PendingMask !== 32'd0) begin n_bad++; $display("FAIL reset_mask: got %h want 0", PendingMask); end
        @(negedge clk); rst = 0;
        step();
    endtask

    task automatic test_wb_only();
        WbValid = 1; WbReg = 5; WbData = 64'h1234;
        step();
        n_cmp++; if (RegWriteEn !== 1'b1) begin n_bad++; $display("FAIL wb_en: got %b want 1", RegWriteEn); end
        n_cmp++; if (Reg2Write !== 5'd5) begin n_bad++; $display("FAIL wb_reg: got %0d want 5", Reg2Write); end
        n_cmp++; if (Data2Write !== 64'h1234) begin n_bad++; $display("FAIL wb_data: got %h want 1234", Data2Write); end
        idle_inputs();
        step();
        n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL wb_idle_en: got %b want 0", RegWriteEn); end
        n_cmp++; if (Reg2Write !== 5'd5) begin n_bad++; $display("FAIL wb_hold_reg: got %0d want 5", Reg2Write); end
    endtask

    task automatic test_ll_only();
        LlValid = 1; LlReg = 7; LlData = 64'hAA;
        step();
        idle_inputs();
        n_cmp++; if (PendingMask !== 32'h80) begin n_bad++; $display("FAIL ll_mask_set: got %h want 80", PendingMask); end
        n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL ll_early_en: got %b want 0", RegWriteEn); end
        step();
        n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'd7 || Data2Write !== 64'hAA) begin
            n_bad++; $display("FAIL ll_write: got en=%b reg=%0d data=%h want 1/7/aa", RegWriteEn, Reg2Write, Data2Write); end
        n_cmp++; if (PendingMask !== 32'd0) begin n_bad++; $display("FAIL ll_mask_clr: got %h want 0", PendingMask); end
        step();
        n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL ll_after_en: got %b want 0", RegWriteEn); end
    endtask

    task automatic test_full();
        WbValid = 1; WbReg = 10; WbData = 64'h100; LlValid = 1; LlReg = 1; LlData = 64'h11;
        step();
        n_cmp++; if (LlReady !== 1'b1) begin n_bad++; $display("FAIL full_ready1: got %b want 1", LlReady); end
        WbReg = 11; WbData = 64'h110; LlReg = 2; LlData = 64'h22;
        step();
        n_cmp++; if (Reg2Write !== 5'd11) begin n_bad++; $display("FAIL full_wb_wins: got %0d want 11", Reg2Write); end
        n_cmp++; if (LlReady !== 1'b0) begin n_bad++; $display("FAIL full_ready0: got %b want 0", LlReady); end
        n_cmp++; if (PendingMask !== 32'h6) begin n_bad++; $display("FAIL full_mask: got %h want 6", PendingMask); end
        // Offered while full: must not be accepted
        WbValid = 0; LlReg = 4; LlData = 64'h44;
        step();
        LlValid = 0;
        n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'd1 || Data2Write !== 64'h11) begin
            n_bad++; $display("FAIL full_pop1: got en=%b reg=%0d data=%h want 1/1/11", RegWriteEn, Reg2Write, Data2Write); end
        n_cmp++; if (LlReady !== 1'b1) begin n_bad++; $display("FAIL full_ready_back: got %b want 1", LlReady); end
        n_cmp++; if (PendingMask !== 32'h4) begin n_bad++; $display("FAIL full_no_passthru: got %h want 4", PendingMask); end
        step();
        n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'd2 || Data2Write !== 64'h22) begin
            n_bad++; $display("FAIL full_pop2: got en=%b reg=%0d data=%h want 1/2/22", RegWriteEn, Reg2Write, Data2Write); end
        step();
        n_cmp++; if (RegWriteEn !== 1'b0 || PendingMask !== 32'd0) begin
            n_bad++; $display("FAIL full_drained: got en=%b mask=%h want 0/0", RegWriteEn, PendingMask); end
    endtask

    task automatic test_starvation();
        LlValid = 1; LlReg = 3; LlData = 64'h33;
        step();
        LlValid = 0;
        for (int i = 0; i < 4; i++) begin
            WbValid = 1; WbReg = 5'(20 + i); WbData = 64'(32'h200 + i);
            step();
            n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'(20 + i)) begin
                n_bad++; $display("FAIL starve_wb%0d: got en=%b reg=%0d want 1/%0d", i, RegWriteEn, Reg2Write, 20 + i); end
            n_cmp++; if (WbStall !== (i == 3)) begin
                n_bad++; $display("FAIL starve_stall%0d: got %b want %b", i, WbStall, i == 3); end
        end
        WbReg = 24; WbData = 64'h240;
        step();
        n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'd3 || Data2Write !== 64'h33) begin
            n_bad++; $display("FAIL starve_force: got en=%b reg=%0d data=%h want 1/3/33", RegWriteEn, Reg2Write, Data2Write); end
        n_cmp++; if (WbStall !== 1'b0) begin n_bad++; $display("FAIL starve_stall_drop: got %b want 0", WbStall); end
        step();
        idle_inputs();
        n_cmp++; if (RegWriteEn !== 1'b1 || Reg2Write !== 5'd24 || Data2Write !== 64'h240) begin
            n_bad++; $display("FAIL starve_held_wb: got en=%b reg=%0d data=%h want 1/24/240", RegWriteEn, Reg2Write, Data2Write); end
        step();
    endtask

    task automatic test_waw_kill();
        LlValid = 1; LlReg = 9; LlData = 64'h99;
        step();
        LlValid = 0;
        n_cmp++; if (PendingMask !== 32'h200) begin n_bad++; $display("FAIL waw_mask_set: got %h want 200", PendingMask); end
        WbValid = 1; WbReg = 9; WbData = 64'h55;
        step();
        WbValid = 0;
        n_cmp++; if (Reg2Write !== 5'd9 || Data2Write !== 64'h55) begin
            n_bad++; $display("FAIL waw_wb: got reg=%0d data=%h want 9/55", Reg2Write, Data2Write); end
        n_cmp++; if (PendingMask !== 32'd0) begin n_bad++; $display("FAIL waw_mask_clr: got %h want 0", PendingMask); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL waw_no_write%0d: got %b want 0", i, RegWriteEn); end
        end
        // Same-cycle push and WB to the same register
        WbValid = 1; WbReg = 9; WbData = 64'h66; LlValid = 1; LlReg = 9; LlData = 64'h77;
        step();
        idle_inputs();
        n_cmp++; if (Data2Write !== 64'h66 || PendingMask !== 32'd0) begin
            n_bad++; $display("FAIL waw_same_cycle: got data=%h mask=%h want 66/0", Data2Write, PendingMask); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL waw_same_no_write%0d: got %b want 0", i, RegWriteEn); end
        end
        n_cmp++; if (LlReady !== 1'b1) begin n_bad++; $display("FAIL waw_ready: got %b want 1", LlReady); end
    endtask

    task automatic test_xzr_and_reset();
        WbValid = 1; WbReg = 31; WbData = 64'hDEAD; LlValid = 1; LlReg = 31; LlData = 64'hBEEF;
        #1;
        n_cmp++; if (LlReady !== 1'b1) begin n_bad++; $display("FAIL xzr_ready: got %b want 1", LlReady); end
        step();
        idle_inputs();
        n_cmp++; if (RegWriteEn !== 1'b0 || Reg2Write !== 5'd9 || PendingMask !== 32'd0) begin
            n_bad++; $display("FAIL xzr_discard: got en=%b reg=%0d mask=%h want 0/9/0", RegWriteEn, Reg2Write, PendingMask); end
        step();
        n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL xzr_late: got %b want 0", RegWriteEn); end
        // Fill the FIFO behind WB traffic, then reset mid-operation
        WbValid = 1; WbReg = 14; WbData = 64'h140; LlValid = 1; LlReg = 12; LlData = 64'hC0;
        step();
        WbReg = 15; WbData = 64'h150; LlReg = 13; LlData = 64'hD0;
        step();
        idle_inputs();
        n_cmp++; if (LlReady !== 1'b0 || PendingMask !== 32'h3000) begin
            n_bad++; $display("FAIL rst_prefill: got ready=%b mask=%h want 0/3000", LlReady, PendingMask); end
        #1 rst = 1;
        #1;
        n_cmp++; if (RegWriteEn !== 1'b0 || Reg2Write !== 5'd0 || Data2Write !== 64'd0 || WbStall !== 1'b0) begin
            n_bad++; $display("FAIL rst_outputs: got en=%b reg=%0d data=%h stall=%b want 0/0/0/0", RegWriteEn, Reg2Write, Data2Write, WbStall); end
        n_cmp++; if (LlReady !== 1'b1 || PendingMask !== 32'd0) begin
            n_bad++; $display("FAIL rst_fifo: got ready=%b mask=%h want 1/0", LlReady, PendingMask); end
        @(negedge clk); rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (RegWriteEn !== 1'b0) begin n_bad++; $display("FAIL rst_discard%0d: got %b want 0", i, RegWriteEn); end
        end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_ll_only();
        test_full();
        test_starvation();
        test_waw_kill();
        test_xzr_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
